// File: rtl/jk_pkg.sv
// Shared JK command encoding and the excitation function used to drive JK cells.
package jk_pkg;

   typedef logic [1:0] jk_cmd_t;

   // Command bits are {J, K}
   localparam jk_cmd_t JK_HOLD = 2'b00;
   localparam jk_cmd_t JK_RST  = 2'b01;
   localparam jk_cmd_t JK_SET  = 2'b10;
   localparam jk_cmd_t JK_TGL  = 2'b11;

   function automatic jk_cmd_t jk_excite(input logic cur, input logic nxt);
      jk_cmd_t cmd;
      cmd = JK_HOLD;
      if (!cur && nxt)
         cmd = JK_SET;
      else if (cur && !nxt)
         cmd = JK_RST;
      return cmd;
   endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for jk_mod_counter; master drives controls, slave is the counter.
interface jk_mod_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up, load, din,
      input  q, tc, wrap
   );

   modport slave (
      input  en, up, load, din,
      output q, tc, wrap
   );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop, asynchronous active-low reset to 0.
import jk_pkg::*;

module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            JK_SET:  q <= 1'b1;
            JK_RST:  q <= 1'b0;
            JK_TGL:  q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from WIDTH JK cells.
// Define JKCNT_SATURATE_EN to saturate at the ends instead of wrapping.
import jk_pkg::*;

module jk_mod_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input logic             clk,
   input logic             reset,
   jk_mod_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0]          q;
   logic [WIDTH-1:0]          n;
   logic                      wrap_n;
   logic                      wrap;
   logic [WIDTH-1:0][1:0]     jk_cmd;

   always_comb begin
      n      = q;
      wrap_n = 1'b0;
      if (bus.load) begin
         n = (32'(bus.din) >= MODULUS) ? MAX_VAL : bus.din;
      end else if (32'(q) >= MODULUS) begin
         // Illegal state recovery, applies even when holding
         n = '0;
      end else if (bus.en) begin
         if (bus.up) begin
            if (q == MAX_VAL) begin
`ifdef JKCNT_SATURATE_EN
               n = q;
`else
               n      = '0;
               wrap_n = 1'b1;
`endif
            end else begin
               n = q + 1'b1;
            end
         end else begin
            if (q == '0) begin
`ifdef JKCNT_SATURATE_EN
               n = q;
`else
               n      = MAX_VAL;
               wrap_n = 1'b1;
`endif
            end else begin
               n = q - 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
      assign jk_cmd[i] = jk_excite(q[i], n[i]);
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (jk_cmd[i][1]),
         .k     (jk_cmd[i][0]),
         .q     (q[i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wrap <= 1'b0;
      else
         wrap <= wrap_n;
   end

   assign bus.q    = q;
   assign bus.wrap = wrap;
   assign bus.tc   = bus.en & (bus.up ? (q == MAX_VAL) : (q == '0));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter with WIDTH=4, MODULUS=10.
`timescale 1ns/1ps
module tb_jk_mod_counter;

   typedef struct {
      logic [3:0] q;
      logic       tc;
      logic       wrap;
      logic       idle;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   jk_mod_counter_if #(.WIDTH(4)) bus ();

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive inputs on the falling edge; the expected state after the next rising edge is queued.
   task automatic step(input logic s_en, input logic s_up, input logic s_ld, input logic [3:0] s_din,
                       input logic [3:0] xq, input logic xtc, input logic xwrap, input logic xidle,
                       input string nm);
      exp_t e;
      @(negedge clk);
      bus.en   = s_en;
      bus.up   = s_up;
      bus.load = s_ld;
      bus.din  = s_din;
      e.q = xq; e.tc = xtc; e.wrap = xwrap; e.idle = xidle; e.name = nm;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".q"},    int'(bus.q),    int'(e.q));
            chk({e.name, ".tc"},   int'(bus.tc),   int'(e.tc));
            chk({e.name, ".wrap"}, int'(bus.wrap), int'(e.wrap));
            if (e.idle)
               chk({e.name, ".jk"}, int'(dut.jk_cmd), 0);
         end
      end
   end

   initial begin : stim
      reset    = 1'b0;
      bus.en   = 1'b1;
      bus.up   = 1'b0;
      bus.load = 1'b0;
      bus.din  = '0;
      #3;
      chk("rst.q",    int'(bus.q),    0);
      chk("rst.wrap", int'(bus.wrap), 0);
      chk("rst.tc",   int'(bus.tc),   1);
      @(negedge clk);
      @(negedge clk);
      bus.en = 1'b0;
      reset  = 1'b1;

      for (int i = 1; i <= 12; i++) begin
`ifdef JKCNT_SATURATE_EN
         step(1, 1, 0, 0, 4'((i > 9) ? 9 : i), (i >= 9), 0, 0, "up_sat");
`else
         step(1, 1, 0, 0, 4'(i % 10), (i == 9), (i == 10), 0, "up");
`endif
      end

      step(0, 0, 1, 2, 2, 0, 0, 0, "load2");
`ifdef JKCNT_SATURATE_EN
      step(1, 0, 0, 0, 1, 0, 0, 0, "dn_sat");
      step(1, 0, 0, 0, 0, 1, 0, 0, "dn_sat");
      step(1, 0, 0, 0, 0, 1, 0, 0, "dn_sat");
      step(1, 0, 0, 0, 0, 1, 0, 0, "dn_sat");
`else
      step(1, 0, 0, 0, 1, 0, 0, 0, "dn");
      step(1, 0, 0, 0, 0, 1, 0, 0, "dn");
      step(1, 0, 0, 0, 9, 0, 1, 0, "dn");
      step(1, 0, 0, 0, 8, 0, 0, 0, "dn");
`endif

      step(1, 1, 1, 13, 9, 1, 0, 0, "clamp");
      step(1, 1, 1, 4,  4, 0, 0, 0, "load_at_max");
      step(0, 0, 1, 4,  4, 0, 0, 0, "load4");

      step(0, 0, 1, 6, 6, 0, 0, 0, "load6");
      for (int i = 0; i < 5; i++)
         step(0, 1, 0, 0, 6, 0, 0, 1, "hold");

      step(0, 1, 1, 5, 5, 0, 0, 0, "load5");
      step(1, 1, 0, 0, 6, 0, 0, 0, "run");
      step(1, 1, 0, 0, 7, 0, 0, 0, "run");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst.q",    int'(bus.q),    0);
      chk("midrst.wrap", int'(bus.wrap), 0);
      chk("midrst.tc",   int'(bus.tc),   0);
      @(negedge clk);
      bus.en = 1'b0;
      reset  = 1'b1;
      step(1, 1, 0, 0, 1, 0, 0, 0, "resume");
      step(1, 1, 0, 0, 2, 0, 0, 0, "resume");
      step(1, 0, 0, 0, 1, 0, 0, 0, "dir_dn");
      step(1, 1, 0, 0, 2, 0, 0, 0, "dir_up");

`ifdef JKCNT_SATURATE_EN
      step(0, 1, 1, 8, 8, 0, 0, 0, "load8");
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 0, 9, 1, 0, 0, "sat_hi");
      step(0, 0, 1, 1, 1, 0, 0, 0, "load1");
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, 0, 0, 1, 0, 0, "sat_lo");
`else
      step(0, 1, 1, 9, 9, 0, 0, 0, "load9");
      step(1, 1, 0, 0, 0, 0, 1, 0, "wrap_up");
      step(0, 1, 0, 0, 0, 0, 0, 0, "wrap_clr");
`endif

      @(negedge clk);
      bus.en   = 1'b0;
      bus.load = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
